// File: rtl/matmul_pkg.sv
// matmul_pkg: state, memory-op and parameter-block encodings shared by the matmul engine.
package matmul_pkg;
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_CHECK  = 4'd2;
    localparam logic [3:0] S_INIT   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_MAC    = 4'd6;
    localparam logic [3:0] S_WRITE  = 4'd7;
    localparam logic [3:0] S_FINISH = 4'd8;
    localparam logic [3:0] S_ERROR  = 4'd9;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b11;

    localparam int M_ACC = 0;
    localparam int M_TR  = 1;
    localparam int M_SAT = 2;
    localparam int M_SGN = 3;

    localparam logic [2:0] P_WA   = 3'd0;
    localparam logic [2:0] P_HA   = 3'd1;
    localparam logic [2:0] P_WB   = 3'd2;
    localparam logic [2:0] P_HB   = 3'd3;
    localparam logic [2:0] P_MODE = 3'd4;
    localparam int N_PARAM = 5;
endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: accumulator with signed/unsigned multiply-add, clear/load and saturating output.
module matmul_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              mac_en,
    input  logic              sgn,
    input  logic              sat,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c_in,
    output logic [DATA_W-1:0] res
);
    localparam int PW = 2 * DATA_W;
    logic [ACC_W-1:0] acc, prod_ext, c_ext;
    logic [PW-1:0] ea, eb, prod;
    logic fits_s, fits_u;

    // Extending operands to 2*DATA_W first makes one multiplier serve both signednesses.
    always_comb begin
        ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
        eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
        prod = ea * eb;
        prod_ext = ACC_W'(prod) | ((sgn && prod[PW-1]) ? ({ACC_W{1'b1}} << PW) : '0);
        c_ext = ACC_W'(c_in) | ((sgn && c_in[DATA_W-1]) ? ({ACC_W{1'b1}} << DATA_W) : '0);
    end

    assign fits_s = &acc[ACC_W-1:DATA_W-1] | ~|acc[ACC_W-1:DATA_W-1];
    assign fits_u = ~|acc[ACC_W-1:DATA_W];
    assign res = (!sat || (sgn ? fits_s : fits_u)) ? acc[DATA_W-1:0] :
                 sgn ? {acc[ACC_W-1], {(DATA_W-1){~acc[ACC_W-1]}}} : '1;

    always_ff @(posedge clk or posedge reset)
        if (reset) acc <= '0;
        else if (clr) acc <= '0;
        else if (load) acc <= c_ext;
        else if (mac_en) acc <= acc + prod_ext;
endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: fetches a parameter block, then computes C = A x B (or C += A x B) over
// the shared single-port memory handshake.
module matmul_engine import matmul_pkg::*; #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int ACC_W      = 64,
    parameter int MAX_DIM    = 256,
    parameter int PARAM_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mem_opdone,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        mem_operation,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int DW = DATA_W > 32 ? DATA_W : 32;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(PARAM_BASE + N_PARAM);

    logic [3:0] state, mode;
    logic [2:0] pidx;
    logic [DATA_W-1:0] wa, ha, wb, hb, i, j, k, a_reg, b_reg, cols, kn, jn, i_n, res;
    logic [ADDR_W-1:0] base_b, base_c, bb_n, addr_n;
    logic mismatch, too_big, empty, is_mem, done_tx;

    assign cols = mode[M_TR] ? hb : wb;
    assign kn = k + DATA_W'(1);
    assign jn = j + DATA_W'(1);
    assign i_n = i + DATA_W'(1);
    assign mismatch = wa != (mode[M_TR] ? wb : hb);
    assign too_big = DW'(wa) > DW'(MAX_DIM) || DW'(ha) > DW'(MAX_DIM) ||
                     DW'(wb) > DW'(MAX_DIM) || DW'(hb) > DW'(MAX_DIM);
    assign empty = ha == '0 || cols == '0 || wa == '0;
    assign bb_n = BASE_A + ADDR_W'(ha) * ADDR_W'(wa);
    assign is_mem = state == S_FETCH || state == S_LOAD_A || state == S_LOAD_B ||
                    state == S_WRITE || (state == S_INIT && mode[M_ACC]);
    assign done_tx = mem_operation != MEM_NONE && mem_opdone;
    assign addr_n = state == S_FETCH  ? ADDR_W'(PARAM_BASE) + ADDR_W'(pidx) :
                    state == S_LOAD_A ? BASE_A + ADDR_W'(i) * ADDR_W'(wa) + ADDR_W'(k) :
                    state == S_LOAD_B ? base_b + (mode[M_TR] ? ADDR_W'(j) * ADDR_W'(wb) + ADDR_W'(k)
                                                             : ADDR_W'(k) * ADDR_W'(wb) + ADDR_W'(j)) :
                    base_c + ADDR_W'(i) * ADDR_W'(cols) + ADDR_W'(j);

    matmul_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .reset(reset),
        .clr(state == S_INIT && !mode[M_ACC]),
        .load(state == S_INIT && done_tx),
        .mac_en(state == S_MAC),
        .sgn(mode[M_SGN]), .sat(mode[M_SAT]),
        .a(a_reg), .b(b_reg), .c_in(data_i), .res(res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            mem_operation <= MEM_NONE;
            addr_o <= '0;
            data_o <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            {wa, ha, wb, hb, i, j, k, a_reg, b_reg} <= '0;
            mode <= '0;
            pidx <= '0;
            base_b <= '0;
            base_c <= '0;
        end else begin
            // Memory states issue from an idle bus, so every transaction is preceded by a 00 cycle.
            if (is_mem && mem_operation == MEM_NONE) begin
                mem_operation <= state == S_WRITE ? MEM_WRITE : MEM_READ;
                addr_o <= addr_n;
                if (state == S_WRITE) data_o <= res;
            end
            if (done_tx) mem_operation <= MEM_NONE;
            case (state)
                S_IDLE: if (enable) begin
                    done <= 1'b0;
                    error <= 1'b0;
                    busy <= 1'b1;
                    pidx <= '0;
                    state <= S_FETCH;
                end
                S_FETCH: if (done_tx) begin
                    if (pidx == P_WA) wa <= data_i;
                    if (pidx == P_HA) ha <= data_i;
                    if (pidx == P_WB) wb <= data_i;
                    if (pidx == P_HB) hb <= data_i;
                    if (pidx == P_MODE) mode <= data_i[3:0];
                    pidx <= pidx + 3'd1;
                    if (pidx == P_MODE) state <= S_CHECK;
                end
                S_CHECK: begin
                    {i, j, k} <= '0;
                    base_b <= bb_n;
                    base_c <= bb_n + ADDR_W'(hb) * ADDR_W'(wb);
                    state <= (mismatch || too_big) ? S_ERROR : empty ? S_FINISH : S_INIT;
                end
                S_INIT: if (!mode[M_ACC] || done_tx) state <= S_LOAD_A;
                S_LOAD_A: if (done_tx) begin
                    a_reg <= data_i;
                    state <= S_LOAD_B;
                end
                S_LOAD_B: if (done_tx) begin
                    b_reg <= data_i;
                    state <= S_MAC;
                end
                S_MAC: begin
                    k <= kn == wa ? '0 : kn;
                    state <= kn == wa ? S_WRITE : S_LOAD_A;
                end
                S_WRITE: if (done_tx) begin
                    j <= jn == cols ? '0 : jn;
                    i <= jn == cols ? i_n : i;
                    state <= (jn == cols && i_n == ha) ? S_FINISH : S_INIT;
                end
                S_FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    error <= 1'b1;
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
